// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a valid/ready request into one SETUP/ACCESS
// transfer and returns a registered response, with an optional bounded-wait abort.
module apb_master_bridge #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter logic        PROT_VAL    = 1'b0
) (
   input  logic                  clock,
   input  logic                  ares,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  rsp_timeout,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  prot,
   output logic                  pstrb,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverror
);

   localparam int unsigned CNT_W    = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CNT_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

   state_e                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pstrb_q, pstrb_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_error_q, rsp_error_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pstrb_d       = pstrb_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_error_d   = rsp_error_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               pwrite_d  = req_write;
               paddr_d   = req_addr;
               pwdata_d  = req_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pstrb_d   = 1'b1;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            if (pready) begin
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_error_d   = pslverror;
               rsp_timeout_d = 1'b0;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               pstrb_d       = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = S_RESP;
            end else if (TIMEOUT_CYC != 0) begin
               // Abort on the TIMEOUT_CYC-th consecutive stalled cycle
               if (cnt_q == CNT_W'(CNT_LAST)) begin
                  rsp_rdata_d   = '0;
                  rsp_error_d   = 1'b1;
                  rsp_timeout_d = 1'b1;
                  psel_d        = 1'b0;
                  penable_d     = 1'b0;
                  pstrb_d       = 1'b0;
                  rsp_valid_d   = 1'b1;
                  state_d       = S_RESP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge ares) begin
      if (!ares) begin
         state_q       <= S_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pstrb_q       <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pstrb_q       <= pstrb_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_error_q   <= rsp_error_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pstrb       = pstrb_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign prot        = PROT_VAL;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: ROM-image APB slave, response scoreboard, per-feature tasks.
module tb_apb_master_bridge;

   logic        clock, ares;
   logic        req_valid, req_ready, req_write;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite, prot, pstrb;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverror;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        to;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_rsp = 0;

   apb_master_bridge #(
      .DATA_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT_CYC(4), .PROT_VAL(1'b0)
   ) dut (
      .clock(clock), .ares(ares),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prot(prot), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverror(pslverror)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ROM image of the downstream slave; word[5] = 0xA5A5_0013
   function automatic logic [31:0] rom_word(input int i);
      return 32'hA5A5_0000 + 32'(i * 3 + 4);
   endfunction

   assign prdata = rom_word(int'(paddr));

   // Scoreboard: pop and compare on every response handshake
   always @(negedge clock) begin
      if (ares && rsp_valid && rsp_ready) begin
         exp_t e;
         n_rsp++;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got rsp rdata=%h err=%b to=%b, no response expected",
                     rsp_rdata, rsp_error, rsp_timeout);
         end else begin
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_error !== e.err || rsp_timeout !== e.to) begin
               n_err++;
               $display("FAIL sb_rsp: got rdata=%h err=%b to=%b, want rdata=%h err=%b to=%b",
                        rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] d, input logic e, input logic t);
      exp_t x;
      x.rdata = d; x.err = e; x.to = t;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      #3;
      n_vec++; if ({psel, penable, pwrite, pstrb, prot} !== 5'b0) begin n_err++; $display("FAIL rst_apb_ctl: got %b want 00000", {psel, penable, pwrite, pstrb, prot}); end
      n_vec++; if (paddr !== 5'd0 || pwdata !== 32'd0) begin n_err++; $display("FAIL rst_apb_data: got paddr=%h pwdata=%h want 0", paddr, pwdata); end
      n_vec++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b0 || rsp_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rsp: got v=%b e=%b t=%b d=%h want 0", rsp_valid, rsp_error, rsp_timeout, rsp_rdata); end
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      step();
      step();
      ares = 1'b1;
      step();
   endtask

   task automatic test_zero_wait_read();
      rsp_ready = 1'b1; pready = 1'b1; pslverror = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
      push_exp(32'hA5A5_0013, 1'b0, 1'b0);
      step();
      req_valid = 1'b0;
      n_vec++; if (psel !== 1'b1 || penable !== 1'b0 || pstrb !== 1'b1) begin n_err++; $display("FAIL zw_c1_setup: got psel=%b penable=%b pstrb=%b want 1 0 1", psel, penable, pstrb); end
      n_vec++; if (paddr !== 5'd5 || req_ready !== 1'b0) begin n_err++; $display("FAIL zw_c1_addr: got paddr=%0d req_ready=%b want 5 0", paddr, req_ready); end
      step();
      n_vec++; if (psel !== 1'b1 || penable !== 1'b1) begin n_err++; $display("FAIL zw_c2_access: got psel=%b penable=%b want 1 1", psel, penable); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0013) begin n_err++; $display("FAIL zw_c3_rsp: got v=%b d=%h want 1 a5a50013", rsp_valid, rsp_rdata); end
      n_vec++; if (psel !== 1'b0 || penable !== 1'b0 || pstrb !== 1'b0) begin n_err++; $display("FAIL zw_c3_idle_bus: got psel=%b penable=%b pstrb=%b want 0", psel, penable, pstrb); end
      step();
      n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL zw_c4_done: got v=%b req_ready=%b want 0 1", rsp_valid, req_ready); end
   endtask

   task automatic test_write_error();
      pready = 1'b1; pslverror = 1'b1; rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd3; req_wdata = 32'hDEAD_BEEF;
      push_exp(32'd0, 1'b1, 1'b0);
      step();
      req_valid = 1'b0; req_wdata = 32'h0;
      n_vec++; if (pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1 || paddr !== 5'd3) begin n_err++; $display("FAIL wr_c1: got pwdata=%h pwrite=%b paddr=%0d want deadbeef 1 3", pwdata, pwrite, paddr); end
      step();
      n_vec++; if (pwdata !== 32'hDEAD_BEEF || penable !== 1'b1) begin n_err++; $display("FAIL wr_c2: got pwdata=%h penable=%b want deadbeef 1", pwdata, penable); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'd0 || rsp_timeout !== 1'b0) begin n_err++; $display("FAIL wr_c3_rsp: got v=%b e=%b d=%h t=%b want 1 1 0 0", rsp_valid, rsp_error, rsp_rdata, rsp_timeout); end
      step();
      pslverror = 1'b0;
   endtask

   task automatic test_wait_backpressure();
      pready = 1'b0; rsp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd9;
      push_exp(rom_word(9), 1'b0, 1'b0);
      step();
      req_valid = 1'b0; req_addr = 5'd0;
      for (int c = 2; c <= 5; c++) begin
         step();
         if (c == 5) pready = 1'b1;
         n_vec++; if (paddr !== 5'd9 || penable !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL ws_c%0d_hold: got paddr=%0d penable=%b v=%b rr=%b want 9 1 0 0", c, paddr, penable, rsp_valid, req_ready); end
      end
      step();
      pready = 1'b0;
      for (int c = 6; c <= 9; c++) begin
         n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== rom_word(9) || rsp_error !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL bp_c%0d_hold: got v=%b d=%h e=%b rr=%b want 1 %h 0 0", c, rsp_valid, rsp_rdata, rsp_error, req_ready, rom_word(9)); end
         step();
      end
      rsp_ready = 1'b1;
      step();
      n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got v=%b rr=%b want 0 1", rsp_valid, req_ready); end
   endtask

   task automatic test_timeout();
      pready = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7;
      push_exp(32'd0, 1'b1, 1'b1);
      step();
      req_valid = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         step();
         n_vec++; if (psel !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL to_c%0d_wait: got psel=%b v=%b want 1 0", c, psel, rsp_valid); end
      end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'd0 || psel !== 1'b0) begin n_err++; $display("FAIL to_c6_abort: got v=%b t=%b e=%b d=%h psel=%b want 1 1 1 0 0", rsp_valid, rsp_timeout, rsp_error, rsp_rdata, psel); end
      step();
      // Same stall, but pready arrives on the cycle the abort would fire
      req_valid = 1'b1; req_addr = 5'd7;
      push_exp(rom_word(7), 1'b0, 1'b0);
      step();
      req_valid = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         step();
         if (c == 5) pready = 1'b1;
      end
      step();
      pready = 1'b0;
      n_vec++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== rom_word(7)) begin n_err++; $display("FAIL to_race: got v=%b t=%b d=%h want 1 0 %h", rsp_valid, rsp_timeout, rsp_rdata, rom_word(7)); end
      step();
   endtask

   task automatic test_reset_mid_access();
      pready = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd2;
      step();
      req_valid = 1'b0;
      step();
      #2 ares = 1'b0;
      #1;
      n_vec++; if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rst_async: got psel=%b penable=%b v=%b rr=%b want 0 0 0 1", psel, penable, rsp_valid, req_ready); end
      step();
      ares = 1'b1;
      pready = 1'b1;
      step();
      req_valid = 1'b1; req_addr = 5'd0;
      push_exp(rom_word(0), 1'b0, 1'b0);
      step();
      req_valid = 1'b0;
      step();
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== rom_word(0)) begin n_err++; $display("FAIL rst_fresh_read: got v=%b d=%h want 1 %h", rsp_valid, rsp_rdata, rom_word(0)); end
      step();
   endtask

   task automatic test_back_to_back();
      int a = 0;
      int last = -1;
      int rsp0 = n_rsp;
      pready = 1'b1; rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b0;
      for (int cyc = 0; cyc < 400 && a < 32; cyc++) begin
         req_addr = 5'(a);
         if (req_ready) begin
            push_exp(rom_word(a), 1'b0, 1'b0);
            if (last >= 0) begin
               n_vec++; if (cyc - last !== 4) begin n_err++; $display("FAIL b2b_spacing: got %0d cycles want 4 at addr %0d", cyc - last, a); end
            end
            last = cyc;
            a++;
         end
         step();
      end
      req_valid = 1'b0;
      n_vec++; if (a !== 32) begin n_err++; $display("FAIL b2b_accepts: got %0d want 32", a); end
      for (int i = 0; i < 5; i++) step();
      n_vec++; if (n_rsp - rsp0 !== 32) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 32", n_rsp - rsp0); end
   endtask

   initial begin
      ares = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'd0; req_wdata = 32'd0;
      rsp_ready = 1'b0; pready = 1'b0; pslverror = 1'b0;
      test_reset();
      test_zero_wait_read();
      test_write_error();
      test_wait_backpressure();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
